// File: rtl/parity_pkg.sv
// Shared types and constants for the framed parity checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int unsigned EVEN     = 0;
  localparam int unsigned ODD      = 1;
  localparam int unsigned ERRCNT_W = 8;

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR tree: parity of one data beat.
module parity_reduce #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  // Reduction XOR across all lanes of the beat
  always_comb begin
    parity = ^data;
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Framed multi-lane parity checker: accumulates parity over FRAME_LEN data
// beats and compares it with a trailing parity beat. All state updates on the
// falling clock edge. Optional macro PARITY_FRAME_ERRCNT_EN builds a saturating
// errored-frame counter; otherwise err_count is constant zero.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned LANES     = 1,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ODD_MODE  = EVEN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_start,
  input  logic [LANES-1:0]    in_data,
  output logic                out_valid,
  output logic                out_parity,
  output logic                out_error,
  output logic                out_abort,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned      CNT_W       = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(FRAME_LEN);
  localparam logic             MODE_BIT    = (ODD_MODE == ODD) ? 1'b1 : 1'b0;
  localparam state_t           FIRST_STATE = (FRAME_LEN == 1) ? PARITY : DATA;

  state_t           state;
  state_t           state_nxt;
  logic             acc;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat_par;
  logic             expected;
  logic             valid_nxt;
  logic             parity_nxt;
  logic             error_nxt;
  logic             abort_nxt;

  parity_reduce #(
    .WIDTH (LANES)
  ) u_reduce (
    .data   (in_data),
    .parity (beat_par)
  );

  assign cnt_inc  = cnt + CNT_W'(1);
  assign expected = acc ^ MODE_BIT;

  // State register
  always_ff @(negedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a start beat always (re)starts a frame
  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (in_start) state_nxt = FIRST_STATE;
        end
        DATA: begin
          if (in_start)                  state_nxt = FIRST_STATE;
          else if (cnt_inc == LAST_BEAT) state_nxt = PARITY;
        end
        PARITY: begin
          state_nxt = in_start ? FIRST_STATE : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    valid_nxt  = 1'b0;
    abort_nxt  = 1'b0;
    parity_nxt = out_parity;
    error_nxt  = out_error;
    if (in_valid) begin
      if (in_start) begin
        acc_nxt   = beat_par;
        cnt_nxt   = CNT_W'(1);
        abort_nxt = (state != IDLE);
      end else begin
        case (state)
          DATA: begin
            acc_nxt = acc ^ beat_par;
            cnt_nxt = cnt_inc;
          end
          PARITY: begin
            valid_nxt  = 1'b1;
            parity_nxt = expected;
            error_nxt  = in_data[0] ^ expected;
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath and output registers
  always_ff @(negedge clock) begin
    if (reset) begin
      acc        <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_error  <= 1'b0;
      out_abort  <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      out_valid  <= valid_nxt;
      out_parity <= parity_nxt;
      out_error  <= error_nxt;
      out_abort  <= abort_nxt;
    end
  end

`ifdef PARITY_FRAME_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_q;

  // Saturating count of errored frames, cleared only by reset
  always_ff @(negedge clock) begin
    if (reset) begin
      err_q <= '0;
    end else if (valid_nxt && error_nxt && (err_q != '1)) begin
      err_q <= err_q + ERRCNT_W'(1);
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule
